reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; NREGS = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports; legal range 1..4.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port write_en  input  1  write request this cycle.
REQ-007 SHALL have port write_addr  input  ADDR_W  destination register.
REQ-008 SHALL have port write_value  input  XLEN  data to write.
REQ-009 SHALL have port rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i is bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port rd_data  output  NUM_RD*XLEN  packed read data; port i is bits [i*XLEN +: XLEN].
REQ-011 SHALL have port busy  output  1  high while the clear sweep runs.
REQ-012 SHALL have port write_rej  output  1  registered one-cycle pulse: previous-cycle write was dropped.

Function
REQ-013 SHALL implement FSM states CLEAR and READY.
REQ-014 CLEAR: a clear pointer starting at 1 SHALL write zero to one register per cycle, then increment.
REQ-015 CLEAR -> READY SHALL occur on the edge that clears register NREGS-1, so busy is high for exactly NREGS-1 cycles after reset release.
REQ-016 READY SHALL be terminal until the next reset.
REQ-017 In READY, write_en=1 with write_addr!=0 SHALL update the register on the rising edge.
REQ-018 Writes to address 0 SHALL be discarded silently, with no write_rej.
REQ-019 In CLEAR, write_en=1 SHALL be discarded, and write_rej SHALL be 1 in the following cycle.
REQ-020 write_rej SHALL be 0 in all other cycles.
REQ-021 Reads SHALL be combinational with no clock latency.
REQ-022 Address 0 SHALL always read 0.
REQ-023 All read ports SHALL read 0 while busy=1, regardless of address.
REQ-024 Read ports SHALL be independent; any number of ports SHALL be allowed to carry the same address.
REQ-025 Data written on edge N SHALL be visible on every read port from cycle N+1 onward.
REQ-026 The clear pointer SHALL be ADDR_W bits wide and SHALL NOT wrap back into the sweep; READY is entered instead.

Reset
REQ-027 reset_n low SHALL asynchronously force state CLEAR, clear pointer 1, busy=1, write_rej=0.
REQ-028 Register array contents SHALL NOT be asynchronously reset; zeroing is done only by the sweep.
REQ-029 reset_n asserted mid-sweep or in READY SHALL restart the full sweep from register 1 after release.

Configuration
REQ-030 Macro REG_FILE_BYPASS_EN SHALL control write-to-read bypass.
REQ-031 With REG_FILE_BYPASS_EN defined, in READY, a read port SHALL return write_value in the same cycle when write_en=1, write_addr==rd_addr[i] and rd_addr[i]!=0.
REQ-032 Without REG_FILE_BYPASS_EN, such a read SHALL return the old register value, and the new value SHALL appear the next cycle.
REQ-033 Bypass SHALL never apply during CLEAR or for address 0.

Verification
REQ-034 Reset release, default params -> busy=1 for exactly 31 cycles, then 0; all rd_data=0 throughout the sweep.
REQ-035 After READY, write x5=0xDEADBEEF, then read x5 on both ports the next cycle -> both ports = 0xDEADBEEF.
REQ-036 Write x0=0xFFFFFFFF, then read x0 -> rd_data=0 and write_rej=0.
REQ-037 write_en=1 on cycle 3 of the sweep -> write_rej=1 on cycle 4 only; after READY, the target register reads 0.
REQ-038 Same-cycle write x7=0x12345678 with rd_addr0=7 -> rd_data0=0x12345678 with the macro defined, previous value without it.
REQ-039 Pulse reset_n low during the sweep at cycle 10 and in READY after writing x3=1 -> sweep restarts (busy 31 cycles) and x3 then reads 0.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with a post-reset clear sweep and x0 hardwired to zero.
// Define REG_FILE_BYPASS_EN to forward a same-cycle write to matching read ports.
module reg_file_mp #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     write_en,
  input  logic [ADDR_W-1:0]        write_addr,
  input  logic [XLEN-1:0]          write_value,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic                     busy,
  output logic                     write_rej
);

  localparam int unsigned NREGS = 1 << ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] clr_ptr_next;
  logic              busy_next;
  logic              write_rej_next;
  logic [XLEN-1:0]   regs [NREGS];

  // Sweep control: last clear of NREGS-1 hands over to READY on the same edge.
  always_comb begin
    next_state     = state;
    clr_ptr_next   = clr_ptr;
    write_rej_next = 1'b0;
    case (state)
      CLEAR: begin
        clr_ptr_next   = clr_ptr + ADDR_W'(1);
        write_rej_next = write_en;
        if (clr_ptr == ADDR_W'(NREGS - 1)) begin
          next_state = READY;
        end
      end
      READY: begin
        next_state = READY;
      end
      default: begin
        next_state = CLEAR;
      end
    endcase
    busy_next = (next_state == CLEAR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= CLEAR;
      clr_ptr   <= ADDR_W'(1);
      busy      <= 1'b1;
      write_rej <= 1'b0;
    end else begin
      state     <= next_state;
      clr_ptr   <= clr_ptr_next;
      busy      <= busy_next;
      write_rej <= write_rej_next;
    end
  end

  // Storage has no reset; the sweep is the only thing that zeroes it.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      regs[clr_ptr] <= '0;
    end else if (write_en && (write_addr != '0)) begin
      regs[write_addr] <= write_value;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [XLEN-1:0] value;
    value = '0;
    if ((state == READY) && (addr != '0)) begin
      value = regs[addr];
`ifdef REG_FILE_BYPASS_EN
      if (write_en && (write_addr == addr)) begin
        value = write_value;
      end
`endif
    end
    return value;
  endfunction

  // Independent combinational read ports.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_data[i*XLEN +: XLEN] = read_port(rd_addr[i*ADDR_W +: ADDR_W]);
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed vector table, sweep/reset sequences and random traffic
// checked against an array-based reference model.
module tb_reg_file_mp;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NUM_RD = 2;
  localparam int unsigned NREGS  = 32;
  localparam int          SWEEP  = 31;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     write_en;
  logic [ADDR_W-1:0]        write_addr;
  logic [XLEN-1:0]          write_value;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*XLEN-1:0]   rd_data;
  logic                     busy;
  logic                     write_rej;

  always #5 clk = ~clk;

  reg_file_mp #(.XLEN(XLEN), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .write_en    (write_en),
    .write_addr  (write_addr),
    .write_value (write_value),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy),
    .write_rej   (write_rej)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: register contents, sweep cycles still to run, pending reject pulse.
  logic [XLEN-1:0] mem [NREGS];
  int              sweep_left;
  bit              rej_exp;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] model_rd(input logic [ADDR_W-1:0] a, input bit we,
                                               input logic [ADDR_W-1:0] wa, input logic [XLEN-1:0] wv);
    if (sweep_left > 0 || a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (we && wa == a) return wv;
`endif
    return mem[a];
  endfunction

  // One cycle: drive at the falling edge, check, advance model on the rising edge.
  task automatic step(input bit we, input logic [ADDR_W-1:0] wa, input logic [XLEN-1:0] wv,
                      input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                      output logic [XLEN-1:0] r0, output logic [XLEN-1:0] r1,
                      output logic rej, output logic bsy);
    write_en    = we;
    write_addr  = wa;
    write_value = wv;
    rd_addr     = {a1, a0};
    #1;
    r0  = rd_data[0 +: XLEN];
    r1  = rd_data[XLEN +: XLEN];
    rej = write_rej;
    bsy = busy;
    chk("rd0", r0, model_rd(a0, we, wa, wv));
    chk("rd1", r1, model_rd(a1, we, wa, wv));
    chk("busy", XLEN'(bsy), XLEN'(sweep_left > 0));
    chk("write_rej", XLEN'(rej), XLEN'(rej_exp));
    @(posedge clk);
    if (sweep_left > 0) begin
      sweep_left--;
      rej_exp = we;
    end else begin
      rej_exp = 1'b0;
      if (we && wa != 0) mem[wa] = wv;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    write_en = 1'b0;
    #1;
    chk("reset_busy", XLEN'(busy), XLEN'(1));
    chk("reset_rej", XLEN'(write_rej), XLEN'(0));
    repeat (2) @(negedge clk);
    reset_n    = 1'b1;
    sweep_left = SWEEP;
    rej_exp    = 1'b0;
    for (int i = 0; i < int'(NREGS); i++) mem[i] = '0;
  endtask

  // Idle cycles with random read addresses until busy drops; returns busy cycle count.
  task automatic run_sweep(output int n);
    logic [XLEN-1:0] r0, r1;
    logic            rj, bs;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      step(1'b0, '0, '0, ADDR_W'($urandom), ADDR_W'($urandom), r0, r1, rj, bs);
      if (!bs) break;
      n++;
    end
  endtask

  typedef struct {
    bit              we;
    logic [ADDR_W-1:0] wa;
    logic [XLEN-1:0] wv;
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    logic [XLEN-1:0] e0;
    logic [XLEN-1:0] e1;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [XLEN-1:0] r0, r1;
    logic            rj, bs;
    int              n;

    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd1,  5'd2,  32'h0,        32'h0};
    tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd4,  5'd5,  32'h0,        32'hDEADBEEF};
    tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
    tbl[4] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    tbl[5] = '{1'b1, 5'd1,  32'h00000001, 5'd31, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5};
    tbl[6] = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd31, 32'h00000001, 32'hA5A5A5A5};

    reset_n = 1'b0; write_en = 1'b0; write_addr = '0; write_value = '0; rd_addr = '0;
    sweep_left = SWEEP; rej_exp = 1'b0;
    @(negedge clk);

    do_reset();
    run_sweep(n);
    chk("busy_cycles", XLEN'(n), XLEN'(SWEEP));

    for (int i = 0; i < 7; i++) begin
      step(tbl[i].we, tbl[i].wa, tbl[i].wv, tbl[i].a0, tbl[i].a1, r0, r1, rj, bs);
      chk($sformatf("tbl%0d_rd0", i), r0, tbl[i].e0);
      chk($sformatf("tbl%0d_rd1", i), r1, tbl[i].e1);
      chk($sformatf("tbl%0d_rej", i), XLEN'(rj), XLEN'(0));
    end

    // Same-cycle write/read of x7.
    step(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, r0, r1, rj, bs);
`ifdef REG_FILE_BYPASS_EN
    chk("bypass_rd0", r0, 32'h12345678);
`else
    chk("bypass_rd0", r0, 32'h0);
`endif
    step(1'b0, '0, '0, 5'd7, 5'd7, r0, r1, rj, bs);
    chk("x7_next_rd0", r0, 32'h12345678);
    chk("x7_next_rd1", r1, 32'h12345678);

    // Write during the sweep is rejected with a single-cycle pulse.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      step(c == 3, 5'd9, 32'hCAFEF00D, 5'd9, 5'd9, r0, r1, rj, bs);
      if (c == 4) chk("rej_pulse", XLEN'(rj), XLEN'(1));
      if (c == 5) chk("rej_drop", XLEN'(rj), XLEN'(0));
    end
    run_sweep(n);
    chk("rest_of_sweep", XLEN'(n), XLEN'(SWEEP - 6));
    step(1'b0, '0, '0, 5'd9, 5'd9, r0, r1, rj, bs);
    chk("x9_after_rej", r0, 32'h0);

    // Reset mid-sweep and again in READY restarts the full sweep.
    do_reset();
    repeat (10) step(1'b0, '0, '0, 5'd3, 5'd0, r0, r1, rj, bs);
    do_reset();
    run_sweep(n);
    chk("restart_busy", XLEN'(n), XLEN'(SWEEP));
    step(1'b1, 5'd3, 32'h1, 5'd0, 5'd0, r0, r1, rj, bs);
    step(1'b0, '0, '0, 5'd3, 5'd3, r0, r1, rj, bs);
    chk("x3_written", r0, 32'h1);
    do_reset();
    run_sweep(n);
    chk("ready_reset_busy", XLEN'(n), XLEN'(SWEEP));
    step(1'b0, '0, '0, 5'd3, 5'd3, r0, r1, rj, bs);
    chk("x3_cleared", r1, 32'h0);

    // Random traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step(1'($urandom_range(0, 2) != 0), ADDR_W'($urandom_range(0, 7)), $urandom,
           ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)), r0, r1, rj, bs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
